// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared types and ISA constants for the hazard scheduler.
// State encoding, opcode values, tag widths, load-use helper.
package pipeline_hazard_controller_pkg;

  localparam int REG_W = 4;
  localparam int OP_W  = 4;
  localparam int CNT_W = 16;

  localparam logic [OP_W-1:0] OP_LW  = 4'h8;
  localparam logic [OP_W-1:0] OP_BEQ = 4'hb;
  localparam logic [OP_W-1:0] OP_B   = 4'hc;
  localparam logic [OP_W-1:0] OP_BL  = 4'hd;
  localparam logic [OP_W-1:0] OP_BR  = 4'he;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  // Register 0 is hardwired, so it never creates a dependency.
  function automatic logic load_use_hit(
    input logic             mem_read,
    input logic [REG_W-1:0] rt_rd,
    input logic [REG_W-1:0] rs,
    input logic [REG_W-1:0] rt
  );
    return mem_read && (rt_rd != '0) &&
           ((rt_rd == rs) || (rt_rd == rt));
  endfunction

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Hazard request / stage control bundle between pipeline and scheduler.
// master: pipeline side (drives requests); slave: scheduler side.
// Counter signals exist only when HAZARD_PERF_CNT_EN is defined.
interface pipeline_hazard_controller_if;
  logic       mem_wait;
  logic       EX_mem_read;
  logic [3:0] EX_rt_rd;
  logic [3:0] ID_rs;
  logic [3:0] ID_rt;
  logic       branch_req;
  logic       PC_write_en;
  logic       IF_ID_write_en;
  logic       ID_EX_write_en;
  logic       EX_MEM_write_en;
  logic       IF_ID_sync_nop;
  logic       ID_EX_sync_nop;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cycles;
  logic [15:0] flush_cycles;
`endif

  modport master (
    output mem_wait, EX_mem_read, EX_rt_rd,
    output ID_rs, ID_rt, branch_req,
`ifdef HAZARD_PERF_CNT_EN
    input  stall_cycles, flush_cycles,
`endif
    input  PC_write_en, IF_ID_write_en,
    input  ID_EX_write_en, EX_MEM_write_en,
    input  IF_ID_sync_nop, ID_EX_sync_nop
  );

  modport slave (
    input  mem_wait, EX_mem_read, EX_rt_rd,
    input  ID_rs, ID_rt, branch_req,
`ifdef HAZARD_PERF_CNT_EN
    output stall_cycles, flush_cycles,
`endif
    output PC_write_en, IF_ID_write_en,
    output ID_EX_write_en, EX_MEM_write_en,
    output IF_ID_sync_nop, ID_EX_sync_nop
  );
endinterface

// File: rtl/pipeline_hazard_controller_perf_cnt.sv
// hazard_perf_counter: 16-bit saturating event counter.
// Ports: clk, i_clr (sync clear), i_en (count), o_count.
module hazard_perf_counter
  import pipeline_hazard_controller_pkg::*;
(
  input  logic             clk,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (i_clr)
      r_cnt <= '0;
    else if (i_en && (r_cnt != '1))
      r_cnt <= r_cnt + 1'b1;
  end

  assign o_count = r_cnt;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Hazard scheduler: freeze > load-use bubble > 2-cycle branch flush.
// Ports: clk, rst_n (sync, active-low), hz (slave modport).
// HAZARD_PERF_CNT_EN adds stall/flush cycle counters.
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  pipeline_hazard_controller_if.slave   hz
);

  state_e r_state;
  state_e w_next;

  logic w_load_use;
  logic w_pc_we;
  logic w_if_id_we;
  logic w_id_ex_we;
  logic w_ex_mem_we;
  logic w_if_id_nop;
  logic w_id_ex_nop;

  assign w_load_use = load_use_hit(hz.EX_mem_read,
                                   hz.EX_rt_rd,
                                   hz.ID_rs,
                                   hz.ID_rt);

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_state <= ST_IDLE;
    else
      r_state <= w_next;
  end

  // Reset forces default controls so a pending
  // flush is dropped while rst_n is low.
  always_comb begin
    w_next      = r_state;
    w_pc_we     = 1'b1;
    w_if_id_we  = 1'b1;
    w_id_ex_we  = 1'b1;
    w_ex_mem_we = 1'b1;
    w_if_id_nop = 1'b0;
    w_id_ex_nop = 1'b0;
    if (!rst_n) begin
      w_next = ST_IDLE;
    end else if (hz.mem_wait) begin
      w_pc_we     = 1'b0;
      w_if_id_we  = 1'b0;
      w_id_ex_we  = 1'b0;
      w_ex_mem_we = 1'b0;
    end else if (r_state == ST_FLUSH) begin
      // ID holds a squashed slot: no interlock,
      // no new branch.
      w_if_id_nop = 1'b1;
      w_next      = ST_IDLE;
    end else if (w_load_use) begin
      w_pc_we     = 1'b0;
      w_if_id_we  = 1'b0;
      w_id_ex_nop = 1'b1;
    end else if (hz.branch_req) begin
      w_if_id_nop = 1'b1;
      w_next      = ST_FLUSH;
    end
  end

  assign hz.PC_write_en     = w_pc_we;
  assign hz.IF_ID_write_en  = w_if_id_we;
  assign hz.ID_EX_write_en  = w_id_ex_we;
  assign hz.EX_MEM_write_en = w_ex_mem_we;
  assign hz.IF_ID_sync_nop  = w_if_id_nop;
  assign hz.ID_EX_sync_nop  = w_id_ex_nop;

`ifdef HAZARD_PERF_CNT_EN
  hazard_perf_counter u_stall_cnt (
    .clk     (clk),
    .i_clr   (!rst_n),
    .i_en    (!w_pc_we),
    .o_count (hz.stall_cycles)
  );

  hazard_perf_counter u_flush_cnt (
    .clk     (clk),
    .i_clr   (!rst_n),
    .i_en    (w_if_id_nop),
    .o_count (hz.flush_cycles)
  );
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: per-cycle vector table
// through a scoreboard queue, plus counter saturation run.
module tb_pipeline_hazard_controller;

  logic clk;
  logic rst_n;

  pipeline_hazard_controller_if u_if ();

  pipeline_hazard_controller u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // exp = {PC_we, IF_ID_we, ID_EX_we, EX_MEM_we, IF_ID_nop, ID_EX_nop}
  localparam logic [5:0] DEF = 6'b111100;
  localparam logic [5:0] FRZ = 6'b000000;
  localparam logic [5:0] LU  = 6'b001101;
  localparam logic [5:0] FL  = 6'b111110;

  typedef struct {
    logic       rst_n;
    logic       mw;
    logic       mr;
    logic [3:0] rd;
    logic [3:0] rs;
    logic [3:0] rt;
    logic       br;
    logic [5:0] exp;
  } vec_t;

  vec_t       tbl[$];
  logic [5:0] sb[$];
  int         n_chk;
  int         n_fail;
  int         exp_stall;
  int         exp_flush;
  logic       cnt_valid;

  function automatic vec_t mk(
    input logic rs_n, input logic mw, input logic mr,
    input logic [3:0] rd, input logic [3:0] rs,
    input logic [3:0] rt, input logic br,
    input logic [5:0] exp
  );
    vec_t v;
    v.rst_n = rs_n; v.mw = mw; v.mr = mr;
    v.rd = rd; v.rs = rs; v.rt = rt;
    v.br = br; v.exp = exp;
    return v;
  endfunction

  function automatic logic [5:0] get_out();
    return {u_if.PC_write_en, u_if.IF_ID_write_en,
            u_if.ID_EX_write_en, u_if.EX_MEM_write_en,
            u_if.IF_ID_sync_nop, u_if.ID_EX_sync_nop};
  endfunction

  task automatic check(input string nm,
                       input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic step(input int idx, input vec_t v);
    logic [5:0] e;
    @(posedge clk);
    #1;
    rst_n            = v.rst_n;
    u_if.mem_wait    = v.mw;
    u_if.EX_mem_read = v.mr;
    u_if.EX_rt_rd    = v.rd;
    u_if.ID_rs       = v.rs;
    u_if.ID_rt       = v.rt;
    u_if.branch_req  = v.br;
    sb.push_back(v.exp);
    @(negedge clk);
    if (sb.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_empty row %0d", idx);
    end else begin
      e = sb.pop_front();
      check($sformatf("ctrl_row%0d", idx), get_out(), e);
    end
`ifdef HAZARD_PERF_CNT_EN
    if (cnt_valid) begin
      check($sformatf("stall_row%0d", idx),
            u_if.stall_cycles, exp_stall);
      check($sformatf("flush_row%0d", idx),
            u_if.flush_cycles, exp_flush);
    end
`endif
    if (!v.rst_n) begin
      exp_stall = 0;
      exp_flush = 0;
      cnt_valid = 1'b1;
    end else begin
      exp_stall += (v.exp[5] ? 0 : 1);
      exp_flush += (v.exp[1] ? 1 : 0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_fail = 0;
    exp_stall = 0; exp_flush = 0;
    cnt_valid = 1'b0;
    rst_n = 1'b0;
    u_if.mem_wait = 1'b0;
    u_if.EX_mem_read = 1'b0;
    u_if.EX_rt_rd = 4'd0;
    u_if.ID_rs = 4'd0;
    u_if.ID_rt = 4'd0;
    u_if.branch_req = 1'b0;

    // reset with branch_req held, then honoured
    tbl.push_back(mk(0,0,0,0,0,0,1,DEF));
    tbl.push_back(mk(0,0,0,0,0,0,1,DEF));
    tbl.push_back(mk(1,0,0,0,0,0,1,FL));
    tbl.push_back(mk(1,0,0,0,0,0,0,FL));
    tbl.push_back(mk(1,0,0,0,0,0,0,DEF));
    // load-use via rs, r0 no stall, via rt, non-load
    tbl.push_back(mk(1,0,1,3,3,0,0,LU));
    tbl.push_back(mk(1,0,0,3,3,0,0,DEF));
    tbl.push_back(mk(1,0,1,0,0,0,0,DEF));
    tbl.push_back(mk(1,0,1,5,2,5,0,LU));
    tbl.push_back(mk(1,0,0,5,5,5,0,DEF));
    // branch pulse, held one more cycle
    tbl.push_back(mk(1,0,0,0,0,0,1,FL));
    tbl.push_back(mk(1,0,0,0,0,0,1,FL));
    tbl.push_back(mk(1,0,0,0,0,0,0,DEF));
    // freeze inside flush
    tbl.push_back(mk(1,0,0,0,0,0,1,FL));
    tbl.push_back(mk(1,1,0,0,0,0,0,FRZ));
    tbl.push_back(mk(1,1,0,0,0,0,0,FRZ));
    tbl.push_back(mk(1,1,0,0,0,0,0,FRZ));
    tbl.push_back(mk(1,0,0,0,0,0,0,FL));
    tbl.push_back(mk(1,0,0,0,0,0,0,DEF));
    // load-use collides with branch
    tbl.push_back(mk(1,0,1,4,4,0,1,LU));
    tbl.push_back(mk(1,0,0,4,4,0,1,FL));
    tbl.push_back(mk(1,0,0,0,0,0,0,FL));
    tbl.push_back(mk(1,0,0,0,0,0,0,DEF));
    // mem_wait beats load-use
    tbl.push_back(mk(1,1,1,4,4,0,0,FRZ));
    tbl.push_back(mk(1,0,1,4,4,0,0,LU));
    // load-use ignored during flush
    tbl.push_back(mk(1,0,0,0,0,0,1,FL));
    tbl.push_back(mk(1,0,1,4,4,0,0,FL));
    tbl.push_back(mk(1,0,0,0,0,0,0,DEF));
    // reset mid-flush drops second NOP
    tbl.push_back(mk(1,0,0,0,0,0,1,FL));
    tbl.push_back(mk(0,0,0,0,0,0,0,DEF));
    tbl.push_back(mk(1,0,0,0,0,0,0,DEF));
    // mem_wait beats branch in IDLE
    tbl.push_back(mk(1,1,0,0,0,0,1,FRZ));
    tbl.push_back(mk(1,0,0,0,0,0,0,DEF));

    foreach (tbl[i]) step(i, tbl[i]);

    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_leftover: got %0d expected 0",
               sb.size());
    end

`ifdef HAZARD_PERF_CNT_EN
    // long freeze saturates the stall counter
    @(posedge clk); #1;
    rst_n = 1'b0;
    u_if.mem_wait = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("stall_after_reset", u_if.stall_cycles, 0);
    for (int k = 0; k < 70000; k++) @(posedge clk);
    @(negedge clk);
    check("stall_saturated", u_if.stall_cycles, 16'hffff);
    check("flush_zero", u_if.flush_cycles, 0);
    check("freeze_ctrl", get_out(), FRZ);
    u_if.mem_wait = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
